// File: rtl/adq_pkg.sv
// Shared types and default parameters for the adq_seq_ctrl multi-channel ADC sequencer.
package adq_pkg;

  typedef enum logic [2:0] {IDLE, CONV, WAIT, WR, ADV, DONE} adq_state_t;

  localparam int N_CH_DEF        = 4;
  localparam int ADC_W_DEF       = 8;
  localparam int ADDR_W_DEF      = 4;
  localparam int SCAN_W_DEF      = 4;
  localparam int EOC_TIMEOUT_DEF = 15;

endpackage

// File: rtl/adq_seq_ctrl_if.sv
// Bus between the ADQ sequencer, the ADC front end and sample RAM.
// ch_mask exists only when ADQ_CH_MASK_EN is defined.
interface adq_seq_ctrl_if
  import adq_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int ADC_W  = ADC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SCAN_W = SCAN_W_DEF
) ();
  localparam int CH_W = $clog2(N_CH);

  // init is a request honoured only when the sequencer is idle; eoc is an
  // acknowledge honoured only while waiting. Outside those states both are ignored.
  logic              init;
  logic [SCAN_W-1:0] n_scans;
  logic [ADDR_W-1:0] base_addr;
  logic              dir;
`ifdef ADQ_CH_MASK_EN
  logic [N_CH-1:0]   ch_mask;
`endif
  logic              eoc;
  logic [ADC_W-1:0]  adc_data;
  logic              sc;
  logic [CH_W-1:0]   ch_sel;
  logic              cs;
  logic              w;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADC_W-1:0]  mem_data;
  logic              busy;
  logic              ack;
  logic              err;
  adq_state_t        state;

  modport master (
    input  init, n_scans, base_addr, dir, eoc, adc_data,
`ifdef ADQ_CH_MASK_EN
    input  ch_mask,
`endif
    output sc, ch_sel, cs, w, mem_addr, mem_data, busy, ack, err, state
  );

  modport slave (
    output init, n_scans, base_addr, dir, eoc, adc_data,
`ifdef ADQ_CH_MASK_EN
    output ch_mask,
`endif
    input  sc, ch_sel, cs, w, mem_addr, mem_data, busy, ack, err, state
  );

endinterface

// File: rtl/adq_addr_cnt.sv
// Loadable up/down address counter; wraps silently modulo 2**ADDR_W.
module adq_addr_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic [ADDR_W-1:0] i_d,
  output logic [ADDR_W-1:0] o_q
);
  logic [ADDR_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_en)   r_q <= i_dir ? r_q + ADDR_W'(1) : r_q - ADDR_W'(1);
  end

  assign o_q = r_q;

endmodule

// File: rtl/adq_seq_ctrl.sv
// Multi-channel ADC acquisition sequencer: bursts of scans, sc/eoc per sample, cs/w to RAM.
// Optional channel mask enabled by defining ADQ_CH_MASK_EN.
module adq_seq_ctrl
  import adq_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int ADC_W       = ADC_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SCAN_W      = SCAN_W_DEF,
  parameter int EOC_TIMEOUT = EOC_TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst,
  adq_seq_ctrl_if.master bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int TMR_W = $clog2(EOC_TIMEOUT + 1);

  adq_state_t        r_state;
  logic [CH_W-1:0]   r_ch;
  logic [SCAN_W-1:0] r_scan;
  logic [SCAN_W-1:0] r_nscans;
  logic              r_dir;
  logic [N_CH-1:0]   r_mask;
  logic [TMR_W-1:0]  r_timer;
  logic [ADC_W-1:0]  r_data;
  logic              r_err;

  logic [N_CH-1:0]   w_mask_in;
  logic              w_any;
  logic [CH_W-1:0]   w_first;
  logic [CH_W-1:0]   w_rfirst;
  logic [CH_W-1:0]   w_next;
  logic              w_has_next;
  logic [SCAN_W-1:0] w_scan_inc;
  logic              w_load;
  logic              w_adv;
  logic [ADDR_W-1:0] w_addr;

`ifdef ADQ_CH_MASK_EN
  assign w_mask_in = bus.ch_mask;
`else
  assign w_mask_in = '1;
`endif

  // Lowest set bit of the incoming mask (for IDLE) and of the latched mask (scan wrap);
  // lowest set bit above the current channel (in-scan advance).
  always_comb begin
    w_any      = |w_mask_in;
    w_first    = '0;
    w_rfirst   = '0;
    w_next     = '0;
    w_has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_mask_in[i]) w_first = CH_W'(i);
      if (r_mask[i])    w_rfirst = CH_W'(i);
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next     = CH_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  assign w_scan_inc = r_scan + SCAN_W'(1);
  assign w_load     = (r_state == IDLE) && bus.init;
  assign w_adv      = (r_state == ADV);

  adq_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_adv),
    .i_dir  (r_dir),
    .i_d    (bus.base_addr),
    .o_q    (w_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_scan   <= '0;
      r_nscans <= '0;
      r_dir    <= 1'b0;
      r_mask   <= '0;
      r_timer  <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.init) begin
          r_nscans <= bus.n_scans;
          r_dir    <= bus.dir;
          r_mask   <= w_mask_in;
          r_ch     <= w_first;
          r_scan   <= '0;
          r_err    <= 1'b0;
          r_state  <= ((bus.n_scans == '0) || !w_any) ? DONE : CONV;
        end
        CONV: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.eoc) begin
            r_data  <= bus.adc_data;
            r_state <= WR;
          end else if (r_timer == TMR_W'(EOC_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        WR: r_state <= ADV;
        ADV: begin
          if (w_has_next) begin
            r_ch    <= w_next;
            r_state <= CONV;
          end else begin
            r_ch    <= w_rfirst;
            r_scan  <= w_scan_inc;
            r_state <= (w_scan_inc == r_nscans) ? DONE : CONV;
          end
        end
        DONE: begin
          r_ch    <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sc       = (r_state == CONV);
  assign bus.ch_sel   = r_ch;
  assign bus.cs       = (r_state == WR);
  assign bus.w        = (r_state == WR);
  assign bus.mem_addr = w_addr;
  assign bus.mem_data = r_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.ack      = (r_state == DONE);
  assign bus.err      = r_err;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_adq_seq_ctrl.sv
// Randomized bench for adq_seq_ctrl against a burst-level reference model.
// Mask tests run only when ADQ_CH_MASK_EN is defined.
module tb_adq_seq_ctrl;
  import adq_pkg::*;

  localparam int N_CH        = 4;
  localparam int ADC_W       = 8;
  localparam int ADDR_W      = 4;
  localparam int SCAN_W      = 4;
  localparam int EOC_TIMEOUT = 15;
  localparam int CH_W        = $clog2(N_CH);
  localparam int NEVER       = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adq_seq_ctrl_if #(.N_CH(N_CH), .ADC_W(ADC_W), .ADDR_W(ADDR_W), .SCAN_W(SCAN_W)) bus ();

  adq_seq_ctrl #(
    .N_CH(N_CH), .ADC_W(ADC_W), .ADDR_W(ADDR_W), .SCAN_W(SCAN_W), .EOC_TIMEOUT(EOC_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADC_W-1:0]  exp_data_q[$];
  logic [CH_W-1:0]   exp_ch_q[$];
  logic              exp_err;
  logic [ADC_W-1:0]  conv_data[64];
  int                conv_dly[64];

  // Conversions happen scan by scan over the enabled channels; the k-th successful
  // sample lands at base +/- k. A sample whose eoc never comes within the timeout ends the burst.
  task automatic build_model(input int n, input logic [ADDR_W-1:0] base, input logic d,
                             input logic [N_CH-1:0] mask);
    int k;
    bit stop;
    exp_addr_q.delete(); exp_data_q.delete(); exp_ch_q.delete();
    exp_err = 1'b0;
    k = 0;
    stop = 1'b0;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!stop && mask[c]) begin
          exp_ch_q.push_back(CH_W'(c));
          if (conv_dly[k] >= EOC_TIMEOUT) begin
            exp_err = 1'b1;
            stop = 1'b1;
          end else begin
            exp_addr_q.push_back(ADDR_W'(int'(base) + (d ? k : -k)));
            exp_data_q.push_back(conv_data[k]);
          end
          k++;
        end
      end
    end
  endtask

  task automatic fill_random(input int timeout_one_in);
    for (int i = 0; i < 64; i++) begin
      conv_data[i] = ADC_W'($urandom);
      conv_dly[i]  = (timeout_one_in > 0 && $urandom_range(timeout_one_in - 1, 0) == 0)
                     ? NEVER : int'($urandom_range(4, 0));
    end
  endtask

  // ---------------- driver + monitor ----------------
  task automatic run_burst(input int n, input logic [ADDR_W-1:0] base, input logic d,
                           input logic [N_CH-1:0] mask, input bit poke_init);
    int cyc, k, cnt, last_cs, last_sc, acks;
    bit done, poked;
    logic [CH_W-1:0] last_ch;
    build_model(n, base, d, mask);
    @(negedge clk);
    bus.init = 1'b1;
    bus.n_scans = SCAN_W'(n);
    bus.base_addr = base;
    bus.dir = d;
`ifdef ADQ_CH_MASK_EN
    bus.ch_mask = mask;
`endif
    @(negedge clk);
    bus.init = 1'b0;
    bus.n_scans = SCAN_W'($urandom);
    bus.base_addr = ADDR_W'($urandom);
    bus.dir = 1'($urandom);
`ifdef ADQ_CH_MASK_EN
    bus.ch_mask = N_CH'($urandom);
`endif
    cyc = 1; k = 0; cnt = -1; last_cs = -100; last_sc = -100; acks = 0;
    done = 1'b0; poked = 1'b0; last_ch = '0;
    while (!done && cyc < 2000) begin
      bus.init = 1'b0;
      check_eq("busy", bus.busy, 1);
      if (bus.sc) begin
        if (exp_ch_q.size() == 0) check_eq("sc_unexpected", 1, 0);
        else check_eq("ch_sel", bus.ch_sel, exp_ch_q.pop_front());
        last_sc = cyc;
        last_ch = bus.ch_sel;
        if (k < 64 && conv_dly[k] == 0) begin
          bus.eoc = 1'b1;
          bus.adc_data = conv_data[k];
          cnt = -1;
        end else begin
          bus.eoc = 1'b0;
          cnt = (k < 64) ? conv_dly[k] : NEVER;
        end
        k++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eoc = 1'b1;
          bus.adc_data = conv_data[k-1];
          cnt = -1;
        end
      end
      if (poke_init && !poked && cyc == last_sc + 1) begin
        bus.init = 1'b1;
        bus.n_scans = '0;
        poked = 1'b1;
      end
      if (bus.cs) begin
        check_eq("w_with_cs", bus.w, 1);
        check_eq("ch_hold", bus.ch_sel, last_ch);
        if (exp_addr_q.size() == 0) check_eq("cs_unexpected", 1, 0);
        else begin
          check_eq("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
          check_eq("mem_data", bus.mem_data, exp_data_q.pop_front());
        end
        last_cs = cyc;
        bus.adc_data = ADC_W'($urandom);
      end
      if (bus.ack) begin
        acks++;
        check_eq("err_at_ack", bus.err, exp_err);
        if (exp_err) check_eq("timeout_lat", cyc - last_sc, EOC_TIMEOUT + 1);
        else if (last_cs > 0) check_eq("ack_after_cs", cyc - last_cs, 2);
        else check_eq("ack_no_conv", (cyc >= 1 && cyc <= 2), 1);
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.init = 1'b0;
    if (!done) check_eq("ack_wait_expired", 0, 1);
    for (int i = 0; i < 3; i++) begin
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_ack", bus.ack, 0);
      check_eq("idle_sc", bus.sc, 0);
      @(negedge clk);
    end
    check_eq("err_sticky", bus.err, exp_err);
    check_eq("ack_count", acks, 1);
    check_eq("writes_left", exp_addr_q.size(), 0);
    check_eq("convs_left", exp_ch_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_sc"}, bus.sc, 0);
    check_eq({tag, "_cs"}, bus.cs, 0);
    check_eq({tag, "_w"}, bus.w, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_ack"}, bus.ack, 0);
    check_eq({tag, "_err"}, bus.err, 0);
    check_eq({tag, "_ch_sel"}, bus.ch_sel, 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_mem_data"}, bus.mem_data, 0);
  endtask

  logic [N_CH-1:0] all_ch;

  initial begin
    all_ch = '1;
    rst = 1'b1;
    bus.init = 1'b0; bus.n_scans = '0; bus.base_addr = '0; bus.dir = 1'b0;
    bus.eoc = 1'b0; bus.adc_data = '0;
`ifdef ADQ_CH_MASK_EN
    bus.ch_mask = '0;
`endif
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // One scan, fixed data A0..A3, eoc 3 cycles after sc.
    for (int i = 0; i < 64; i++) begin
      conv_data[i] = ADC_W'(8'hA0 + i);
      conv_dly[i]  = 3;
    end
    run_burst(1, 4'd0, 1'b1, all_ch, 1'b0);

    // Decrementing with wrap, two scans.
    fill_random(0);
    run_burst(2, 4'd1, 1'b0, all_ch, 1'b0);

    // Timeout on first sample, then a clean burst clears err.
    fill_random(0);
    conv_dly[0] = NEVER;
    run_burst(1, 4'd5, 1'b1, all_ch, 1'b0);
    fill_random(0);
    run_burst(1, 4'd9, 1'b1, all_ch, 1'b0);

    // init pulsed during WAIT is ignored.
    fill_random(0);
    for (int i = 0; i < 64; i++) conv_dly[i] = 3;
    run_burst(2, 4'd3, 1'b1, all_ch, 1'b1);

    // Reset while in WAIT aborts at once.
    for (int i = 0; i < 64; i++) conv_dly[i] = NEVER;
    @(negedge clk);
    bus.eoc = 1'b0;
    bus.init = 1'b1; bus.n_scans = 4'd2; bus.base_addr = 4'd7; bus.dir = 1'b1;
`ifdef ADQ_CH_MASK_EN
    bus.ch_mask = all_ch;
`endif
    @(negedge clk);
    bus.init = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_in_wait");
    @(negedge clk);
    rst = 1'b0;
    bus.eoc = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_busy", bus.busy, 0);
      check_eq("post_rst_cs", bus.cs, 0);
    end

    // Zero-scan burst.
    run_burst(0, 4'd2, 1'b1, all_ch, 1'b0);

`ifdef ADQ_CH_MASK_EN
    fill_random(0);
    run_burst(1, 4'd0, 1'b1, 4'b1010, 1'b0);
    run_burst(2, 4'd0, 1'b1, 4'b0000, 1'b0);
`endif

    // Randomized bursts.
    for (int t = 0; t < 10; t++) begin
      fill_random(20);
`ifdef ADQ_CH_MASK_EN
      run_burst($urandom_range(3, 0), ADDR_W'($urandom), 1'($urandom), N_CH'($urandom), 1'b0);
`else
      run_burst($urandom_range(3, 0), ADDR_W'($urandom), 1'($urandom), all_ch, 1'b0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
